pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline stage register. Successor to the fixed-field, stall-only inter-stage flops (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary data bundle plus a control bundle between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready, so there is no combinational ready path across stages.
- A synchronous flush squashes in-flight entries, so hazard and branch logic can insert bubbles without per-field muxing.

---
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline stage with a 2-entry skid buffer.
// The main entry drives the outputs; the skid entry catches the one transfer that
// can land while in_ready (a decoded flop) is still high as downstream stalls.
// Flush squashes held entries (ctrl -> CTRL_BUBBLE, data held).
// Optional macro PIPE_STAGE_STATS_EN adds saturating stall/squash counters.
module pipe_stage_reg #(
  parameter int                 DATA_W      = 32,
  parameter int                 CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
`ifdef PIPE_STAGE_STATS_EN
  , parameter int               CNT_W       = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] squash_cnt
`endif
);

  // Occupancy state; the entry valid bits are decoded from it.
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} st_e;

  st_e               state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              accept, drain;

  // State and entry registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Next-state and entry movement; flush wins over any accept in the same cycle.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    accept      = in_valid & in_ready;
    drain       = out_valid & out_ready;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
      skid_ctrl_d = CTRL_BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the skid-to-main move can happen.
          if (drain) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = CTRL_BUBBLE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs decode only registered state, so no ready path crosses the stage.
  always_comb begin
    out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
    in_ready  = (state_q != ST_TWO);
    out_data  = main_data_q;
    out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, squash_cnt_q, squash_cnt_d;
  logic [CNT_W:0]   squash_sum;
  logic [1:0]       squash_n;

  // Statistics counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  // Saturating updates; an entry drained in the flush cycle is not a squash.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    squash_n = 2'd0;
    if (flush) begin
      if (state_q == ST_TWO)                squash_n = drain ? 2'd1 : 2'd2;
      else if (state_q == ST_ONE && !drain) squash_n = 2'd1;
    end
    squash_sum   = {1'b0, squash_cnt_q} + {{(CNT_W-1){1'b0}}, squash_n};
    squash_cnt_d = squash_sum[CNT_W] ? '1 : squash_sum[CNT_W-1:0];
  end

  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed + randomized bench for pipe_stage_reg, checked
// against a 2-deep FIFO queue reference model.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]   stall_cnt, squash_cnt;
  int unsigned   stall_m = 0, squash_m = 0;
`endif

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [CW-1:0] c; logic [DW-1:0] d;} ent_t;
  ent_t mq[$];
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a FIFO of at most two entries, advanced once per clock edge.
  task automatic model_edge();
    bit rdy, drn, acc;
    if (!rst_n) begin
      mq.delete();
`ifdef PIPE_STAGE_STATS_EN
      stall_m = 0; squash_m = 0;
`endif
      return;
    end
    rdy = (mq.size() < 2);
    drn = (mq.size() > 0) && out_ready;
    acc = in_valid && rdy;
`ifdef PIPE_STAGE_STATS_EN
    if (mq.size() > 0 && !out_ready && stall_m < 65535) stall_m++;
    if (flush) begin
      squash_m = squash_m + mq.size() - (drn ? 1 : 0);
      if (squash_m > 65535) squash_m = 65535;
    end
`endif
    if (flush) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back({in_ctrl, in_data});
    end
  endtask

  task automatic chk_out();
    chk("out_valid", out_valid, mq.size() > 0);
    chk("in_ready", in_ready, mq.size() < 2);
    if (mq.size() > 0) begin
      chk("out_ctrl", out_ctrl, mq[0].c);
      chk("out_data", out_data, mq[0].d);
    end else begin
      chk("out_ctrl_bubble", out_ctrl, 8'h00);
    end
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", stall_cnt, stall_m);
    chk("squash_cnt", squash_cnt, squash_m);
`endif
  endtask

  task automatic cyc(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input bit ordy, input bit fl);
    in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    chk_out();
  endtask

  initial begin
    bit            pv, pr, pf, quiet;
    logic [CW-1:0] pc;
    logic [DW-1:0] pd;
`ifdef PIPE_STAGE_STATS_EN
    int unsigned   sq0;
`endif

    // Reset held for 3 cycles.
    repeat (3) cyc(1'b1, 8'hFF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("rst_data", out_data, 32'h0);
    rst_n = 1'b1;

    // Stream 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, CW'(i), DW'(i), 1'b1, 1'b0);
      chk("stream_data", out_data, DW'(i));
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure fills both entries.
    cyc(1'b1, 8'h11, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 32'hB, 1'b0, 1'b0);
    chk("bp_ready_low", in_ready, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("bp_hold", {out_ctrl, out_data}, {8'h11, 32'hA});
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("bp_second", {out_ctrl, out_data}, {8'h22, 32'hB});
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("bp_empty", {out_valid, out_ctrl}, {1'b0, 8'h00});

    // Flush while full, with a competing accept.
    cyc(1'b1, 8'h01, 32'hC, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 32'hD, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
    sq0 = squash_m;
`endif
    cyc(1'b1, 8'h03, 32'hE, 1'b0, 1'b1);
    chk("flush_two", {out_valid, in_ready, out_ctrl}, {1'b1 ^ 1'b1, 1'b1, 8'h00});
`ifdef PIPE_STAGE_STATS_EN
    chk("flush_two_sq", squash_cnt, sq0 + 2);
`endif
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_no_E", out_valid, 1'b0);

    // Flush coinciding with a drain.
    cyc(1'b1, 8'h05, 32'h5, 1'b0, 1'b0);
    chk("fd_main", out_data, 32'h5);
`ifdef PIPE_STAGE_STATS_EN
    sq0 = squash_m;
`endif
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    chk("fd_empty", out_valid, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
    chk("fd_sq", squash_cnt, sq0);
`endif

    // Random traffic; some 100-cycle windows carry no flush at all.
    pv = 1'b0; pr = 1'b1; pf = 1'b0; pc = '0; pd = '0; quiet = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (i % 100 == 0) quiet = ($urandom_range(99) < 30);
      pv = out_valid; pc = out_ctrl; pd = out_data;
      pr = ($urandom_range(99) < 60);
      pf = !quiet && ($urandom_range(99) < 4);
      cyc($urandom_range(99) < 65, CW'($urandom), $urandom, pr, pf);
      if (pv && !pr && !pf) chk("stall_hold", {out_ctrl, out_data}, {pc, pd});
    end

    // Async reset between edges while full.
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    cyc(1'b1, 8'h07, 32'h7, 1'b0, 1'b0);
    cyc(1'b1, 8'h08, 32'h8, 1'b0, 1'b0);
    chk("ar_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_ready", in_ready, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, 1'b0);

`ifdef PIPE_STAGE_STATS_EN
    // Long stall drives stall_cnt into saturation.
    cyc(1'b1, 8'h09, 32'h9, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", stall_cnt, 16'hFFFF);
    stall_m = 65535;
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
